handshake_ctrl_rr_arbiter: RTL

Round-robin arbiter that lets NUM_INPUTS control-token producers share one downstream handshake consumer, for example a shared constant generator or a shared operator's control port. Each cycle it selects one valid requester and latches the winner's index into a one-slot output register. It then presents that index as a token on the output channel. It sits between the dataflow control network and the shared resource. Downstream logic uses the emitted index to route results back to the winning requester.

---
 rtl/handshake_ctrl_rr_arbiter_pkg.sv | 14 +
 rtl/handshake_ctrl_rr_arbiter_if.sv | 30 +++
 rtl/handshake_ctrl_rr_arbiter_picker.sv | 30 +++
 rtl/handshake_ctrl_rr_arbiter.sv | 68 ++++++
 4 files changed

// File: rtl/handshake_ctrl_rr_arbiter_pkg.sv
// Shared constants and helpers for the handshake arbiter family.
package handshake_pkg;

  localparam logic RST_ASSERTED = 1'b0;

  // Index width needed to name n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/handshake_ctrl_rr_arbiter_if.sv
// Bundle of per-requester valid/ready lines and the indexed output token channel.
interface handshake_ctrl_rr_arbiter_if #(
  parameter int NUM_INPUTS  = 4,
  parameter int INDEX_WIDTH = 2
);

  logic [NUM_INPUTS-1:0]  ins_valid;
  logic [NUM_INPUTS-1:0]  ins_ready;
  logic [INDEX_WIDTH-1:0] outs;
  logic                   outs_valid;
  logic                   outs_ready;

  // master: requesters plus the downstream consumer; slave: the arbiter itself
  modport master (
    output ins_valid,
    output outs_ready,
    input  ins_ready,
    input  outs,
    input  outs_valid
  );

  modport slave (
    input  ins_valid,
    input  outs_ready,
    output ins_ready,
    output outs,
    output outs_valid
  );

endinterface

// File: rtl/handshake_ctrl_rr_arbiter_picker.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Zero latency; no state, so no backpressure of its own.
module handshake_rr_picker #(
  parameter int NUM_INPUTS  = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic [NUM_INPUTS-1:0]  req,
  input  logic [INDEX_WIDTH-1:0] ptr,
  output logic                   any,
  output logic [INDEX_WIDTH-1:0] winner,
  output logic [NUM_INPUTS-1:0]  grant
);

  always_comb begin
    int idx;
    any    = 1'b0;
    winner = '0;
    grant  = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      if (!any && req[idx]) begin
        any        = 1'b1;
        winner     = INDEX_WIDTH'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/handshake_ctrl_rr_arbiter.sv
// Round-robin arbiter feeding a one-slot registered index token; 1-cycle latency.
// Accepts whenever the slot is empty or draining this cycle (outs_ready -> ins_ready is combinational).
module handshake_ctrl_rr_arbiter
  import handshake_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  handshake_ctrl_rr_arbiter_if.slave    bus
);

  if (NUM_INPUTS < 1 || INDEX_WIDTH < clog2_min1(NUM_INPUTS)) begin : g_bad_params
    $error("INDEX_WIDTH too narrow for NUM_INPUTS");
  end

  logic [INDEX_WIDTH-1:0] ptr;
  logic [INDEX_WIDTH-1:0] ptr_nxt;
  logic [INDEX_WIDTH-1:0] winner;
  logic [INDEX_WIDTH-1:0] slot_idx;
  logic [NUM_INPUTS-1:0]  grant;
  logic                   any;
  logic                   slot_vld;
  logic                   can_accept;
  logic                   take;
  logic                   in_reset;

  handshake_rr_picker #(
    .NUM_INPUTS  (NUM_INPUTS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_picker (
    .req    (bus.ins_valid),
    .ptr    (ptr),
    .any    (any),
    .winner (winner),
    .grant  (grant)
  );

  assign in_reset   = (rst == RST_ASSERTED);
  assign can_accept = !slot_vld || bus.outs_ready;
  assign take       = can_accept && any && !in_reset;

  assign bus.ins_ready  = take ? grant : '0;
  assign bus.outs       = slot_idx;
  assign bus.outs_valid = slot_vld;

  // Pointer lands just past the winner, wrapping at NUM_INPUTS rather than 2**INDEX_WIDTH.
  always_comb begin
    ptr_nxt = '0;
    if (int'(winner) != NUM_INPUTS - 1) ptr_nxt = winner + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_vld <= 1'b0;
      slot_idx <= '0;
      ptr      <= '0;
    end else if (take) begin
      slot_vld <= 1'b1;
      slot_idx <= winner;
      ptr      <= ptr_nxt;
    end else if (bus.outs_ready) begin
      slot_vld <= 1'b0;
    end
  end

endmodule
